// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared definitions for the LC-3 two-core memory arbiter.
package lc3_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared memory.
interface lc3_mem_arbiter_if
  import lc3_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic              memwe;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] memOut;
  logic              busy;
  logic              gnt_id;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memOut,
    output ack0, ack1, rdata, memwe, mar, mdr, busy, gnt_id
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memOut,
    input  ack0, ack1, rdata, memwe, mar, mdr, busy, gnt_id
  );

endinterface

// File: rtl/lc3_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on contention, the port not served last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  assign valid_o  = |req_i;
  assign winner_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one memory between two LC-3 cores; one access per 3 cycles.
// state     | meaning
// ST_IDLE   | waiting; winner's request latched on grant
// ST_ACCESS | mar/mdr/memwe presented to memory
// ST_RESP   | memory data returned, ack pulses to granted port
module lc3_mem_arbiter
  import lc3_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  lc3_mem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              gnt_q;
  logic              last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              pick_valid;
  logic              pick_winner;
  logic              grant;

  rr_pick2 u_pick (
    .req_i    ({bus.req1, bus.req0}),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  assign grant = (state_q == ST_IDLE) && pick_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // last_q resets to 1 so that a tie right after reset goes to port 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (grant) begin
        gnt_q   <= pick_winner;
        last_q  <= pick_winner;
        we_q    <= pick_winner ? bus.we1    : bus.we0;
        addr_q  <= pick_winner ? bus.addr1  : bus.addr0;
        wdata_q <= pick_winner ? bus.wdata1 : bus.wdata0;
      end
      if ((state_q == ST_RESP) && !we_q) begin
        rdata_q <= bus.memOut;
      end
    end
  end

  // Outputs decode the async-reset state directly, so reset kills memwe/ack at once
  always_comb begin
    bus.memwe = 1'b0;
    bus.ack0  = 1'b0;
    bus.ack1  = 1'b0;
    bus.rdata = rdata_q;
    unique case (state_q)
      ST_ACCESS: bus.memwe = we_q;
      ST_RESP: begin
        bus.ack0 = ~gnt_q;
        bus.ack1 = gnt_q;
        if (!we_q) bus.rdata = bus.memOut;
      end
      default: ;
    endcase
  end

  assign bus.mar    = addr_q;
  assign bus.mdr    = wdata_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.gnt_id = gnt_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter with a registered-read memory model.
module tb_lc3_mem_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  logic [15:0] mem [0:65535];

  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // shared memory: registered read, old data returned on a same-cycle write
  always @(posedge clk) begin
    bus.memOut <= mem[bus.mar];
    if (bus.memwe) mem[bus.mar] = bus.mdr;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: each ack pops the oldest expected completion
  always @(posedge clk) begin
    #1;
    if (bus.ack0 || bus.ack1) begin
      check_eq("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 0);
      check_eq("sb_nonempty", {31'd0, sb_q.size() != 0}, 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_port", {31'd0, bus.ack1}, {31'd0, e.port});
        if (!e.we) check_eq("sb_rdata", {16'd0, bus.rdata}, {16'd0, e.rdata});
      end
    end
  end

  task automatic push_exp(input logic port, input logic we, input logic [15:0] rd);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.rdata = rd;
    sb_q.push_back(e);
  endtask

  // call at posedge+1 with the arbiter idle; returns at posedge+1 back in IDLE
  task automatic do_access(input logic port, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] exp_rd);
    logic got;
    push_exp(port, we, exp_rd);
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
    end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk); #1;
      got = port ? bus.ack1 : bus.ack0;
    end
    check_eq("ack_wait", {31'd0, got}, 1);
    if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n_ack;
    int last_ack;
    logic [15:0] a, d;
    logic p;

    reset = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    mem[16'h3000] = 16'h1234;
    mem[16'h0010] = 16'h1111;
    mem[16'h0020] = 16'h2222;
    mem[16'h0050] = 16'hAAAA;

    #3;
    check_eq("rst_memwe", {31'd0, bus.memwe}, 0);
    check_eq("rst_mar", {16'd0, bus.mar}, 0);
    check_eq("rst_mdr", {16'd0, bus.mdr}, 0);
    check_eq("rst_rdata", {16'd0, bus.rdata}, 0);
    check_eq("rst_acks", {30'd0, bus.ack1, bus.ack0}, 0);
    check_eq("rst_gnt", {31'd0, bus.gnt_id}, 0);
    check_eq("rst_busy", {31'd0, bus.busy}, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // single read
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h3000;
    push_exp(1'b0, 1'b0, 16'h1234);
    @(posedge clk); #1;
    check_eq("rd_mar", {16'd0, bus.mar}, 32'h3000);
    check_eq("rd_memwe", {31'd0, bus.memwe}, 0);
    check_eq("rd_busy", {31'd0, bus.busy}, 1);
    check_eq("rd_ack_early", {31'd0, bus.ack0}, 0);
    @(posedge clk); #1;
    check_eq("rd_ack", {31'd0, bus.ack0}, 1);
    check_eq("rd_data", {16'd0, bus.rdata}, 32'h1234);
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    check_eq("rd_ack_once", {31'd0, bus.ack0}, 0);
    check_eq("rd_idle", {31'd0, bus.busy}, 0);

    // single write, then read-back
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0040; bus.wdata1 = 16'hBEEF;
    push_exp(1'b1, 1'b1, 16'h0);
    @(posedge clk); #1;
    check_eq("wr_memwe", {31'd0, bus.memwe}, 1);
    check_eq("wr_mar", {16'd0, bus.mar}, 32'h0040);
    check_eq("wr_mdr", {16'd0, bus.mdr}, 32'hBEEF);
    check_eq("wr_gnt", {31'd0, bus.gnt_id}, 1);
    @(posedge clk); #1;
    check_eq("wr_memwe_off", {31'd0, bus.memwe}, 0);
    check_eq("wr_ack", {31'd0, bus.ack1}, 1);
    check_eq("wr_rdata_hold", {16'd0, bus.rdata}, 32'h1234);
    check_eq("wr_mdr_hold", {16'd0, bus.mdr}, 32'hBEEF);
    bus.req1 = 1'b0;
    @(posedge clk); #1;
    check_eq("wr_mem", {16'd0, mem[16'h0040]}, 32'hBEEF);
    do_access(1'b0, 1'b0, 16'h0040, 16'h0, 16'hBEEF);

    // contention from reset
    reset = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0020;
    push_exp(1'b0, 1'b0, 16'h1111);
    push_exp(1'b1, 1'b0, 16'h2222);
    push_exp(1'b0, 1'b0, 16'h1111);
    push_exp(1'b1, 1'b0, 16'h2222);
    @(posedge clk); #1;
    reset = 1'b0;
    n_ack = 0;
    last_ack = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.ack0 || bus.ack1) begin
        if (n_ack == 0) check_eq("cont_first_ack", i, 2);
        else check_eq("cont_ack_gap", i - last_ack, 3);
        last_ack = i;
        n_ack++;
        if (n_ack == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
    end
    check_eq("cont_n_ack", n_ack, 4);
    @(posedge clk); #1;
    check_eq("cont_idle", {31'd0, bus.busy}, 0);

    // reset during a write access
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0050; bus.wdata0 = 16'h5555;
    @(posedge clk); #1;
    check_eq("mid_memwe", {31'd0, bus.memwe}, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_memwe_drop", {31'd0, bus.memwe}, 0);
    check_eq("mid_busy", {31'd0, bus.busy}, 0);
    check_eq("mid_mar", {16'd0, bus.mar}, 0);
    check_eq("mid_mdr", {16'd0, bus.mdr}, 0);
    check_eq("mid_rdata", {16'd0, bus.rdata}, 0);
    check_eq("mid_acks", {30'd0, bus.ack1, bus.ack0}, 0);
    check_eq("mid_gnt", {31'd0, bus.gnt_id}, 0);
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_mem", {16'd0, mem[16'h0050]}, 32'hAAAA);
    reset = 1'b0;

    // early drop of req0; tie after reset must favour port 0
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0020;
    push_exp(1'b0, 1'b0, 16'h1111);
    push_exp(1'b1, 1'b0, 16'h2222);
    @(posedge clk); #1;
    check_eq("drop_gnt0", {31'd0, bus.gnt_id}, 0);
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    check_eq("drop_ack0", {31'd0, bus.ack0}, 1);
    @(posedge clk); #1;
    check_eq("drop_idle", {31'd0, bus.busy}, 0);
    @(posedge clk); #1;
    check_eq("drop_gnt1", {31'd0, bus.gnt_id}, 1);
    check_eq("drop_busy1", {31'd0, bus.busy}, 1);
    @(posedge clk); #1;
    check_eq("drop_ack1", {31'd0, bus.ack1}, 1);
    bus.req1 = 1'b0;
    @(posedge clk); #1;

    // random write / cross-port read-back
    for (int k = 0; k < 4; k++) begin
      p = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(16'h0100, 16'h01ff));
      d = 16'($urandom);
      do_access(p, 1'b1, a, d, 16'h0);
      do_access(~p, 1'b0, a, 16'h0, d);
    end

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
